rr_sel4_arb: RTL and testbench
==============================

Name: rr_sel4_arb

Overview:
- Four-requester round-robin arbiter and output register for the 64-bit 4:1 select datapath.
- Decides which of four sources X1..X4 is forwarded, produces the 2-bit select code, and captures the chosen word into a single-entry output register.
- Uses a valid/ready handshake toward the downstream consumer.
- Turns the combinational mux into a fair, flow-controlled stage.

Parameters:
- N, 64, data width of each source and of the output word.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  per-source request; bit0=X1 .. bit3=X4
- X1  input  N  source 0 data, stable while req[0]=1 until acked
- X2  input  N  source 1 data
- X3  input  N  source 2 data
- X4  input  N  source 3 data
- ack  output  4  one-hot, combinational; ack[i]=1 in the cycle source i is captured
- select  output  2  registered code of the source currently held in q (0=X1 .. 3=X4)
- q  output  N  registered output word
- q_valid  output  1  q holds an unconsumed word
- q_ready  input  1  downstream accepts q when q_valid & q_ready at the clock edge

Behaviour:
- Reset: the asynchronous assert of rst_n=0 forces q=0, select=0, q_valid=0, ptr=0 and state EMPTY; ack=0 while in reset.
- Internal ptr (2 bits) is the highest-priority source. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- load = !q_valid | q_ready, i.e. the register is empty or is being drained this cycle.
- grant = first i in priority order with req[i]=1. It is computed only when load=1.
- On a clock edge with load=1 and req!=0:
  - q <= X[grant]
  - select <= grant
  - q_valid <= 1
  - ptr <= grant+1 (mod 4, 3 wraps to 0)
  - ack[grant]=1 during that cycle
- On a clock edge with load=1 and req=0: q_valid <= 0. q and select hold their old values. ptr is unchanged.
- On a clock edge with load=0 (q_valid=1, q_ready=0): q, select, q_valid and ptr all hold, and ack=0. Sources keep requesting.
- State machine:
  - EMPTY: q_valid=0. Any req moves to FULL.
  - FULL: q_valid=1.
    - q_ready=1 and req!=0 stays in FULL and reloads (back-to-back, one word per cycle).
    - q_ready=1 and req=0 moves to EMPTY.
    - q_ready=0 stays in FULL.
- Latency: one cycle from a granted req to q_valid/q. Full throughput is one word per cycle.
- Fairness: a source holding req high is granted within at most 4 accepted transfers.
- ack is a single-cycle pulse per captured word. A source that keeps req high after ack is treated as presenting a new word.
- A simultaneous drain and load in the same cycle is legal and loses no data.
- req changing while load=0 has no effect until the next load cycle.
- A reset asserted mid-transfer discards the held word. No ack is issued during reset. After release, arbitration restarts at X1.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 and q_ready=1 -> q_valid=0, q=0, select=0, ack=0. Release -> first grant is X1, with select=0 and ack=4'b0001.
- Single source: X3=64'hDEAD_BEEF_0000_0003, req=4'b0100 pulsed one cycle, q_ready=1 -> next cycle q=64'hDEAD_BEEF_0000_0003, select=2, q_valid=1. Cycle after -> q_valid=0.
- Round-robin: req=4'b1111 held, q_ready=1 for 8 cycles -> select sequence 0,1,2,3,0,1,2,3 and ack one-hot rotating each cycle.
- Skip and wrap: ptr=3 after a grant to X3, then req=4'b0011 -> grant X1 (select=0), then X2 (select=1).
- Backpressure: q valid with X2 word 64'h2, q_ready=0 for 5 cycles, req=4'b1111 -> q, select=1 and q_valid stable, ack=0 throughout. Raise q_ready -> next grant is X3 (select=2).
- Mid-operation reset: FULL with select=3, assert rst_n=0 asynchronously between edges -> q_valid drops immediately to 0 with q=0. After release with req=4'b1000 -> select=3 captured one cycle later.

Source files
------------

// File: rtl/rr_sel4_if.sv
// Handshake bundle between four data sources, the round-robin output stage
// and its downstream consumer.
interface rr_sel4_if #(
  parameter int N = 64
);
  logic [3:0]   req;
  logic [N-1:0] X1;
  logic [N-1:0] X2;
  logic [N-1:0] X3;
  logic [N-1:0] X4;
  logic [3:0]   ack;
  logic [1:0]   select;
  logic [N-1:0] q;
  logic         q_valid;
  logic         q_ready;

  modport master (
    output req, X1, X2, X3, X4, q_ready,
    input  ack, select, q, q_valid
  );

  modport slave (
    input  req, X1, X2, X3, X4, q_ready,
    output ack, select, q, q_valid
  );
endinterface

// File: rtl/rr_sel4_arb.sv
// Four-source round-robin arbiter feeding a single-entry valid/ready output
// register; one word per cycle when the consumer keeps q_ready high.
module rr_sel4_arb #(
  parameter int N = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_sel4_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_p0;
  state_t       state_nxt;
  logic [1:0]   ptr_p0;
  logic [1:0]   ptr_nxt;
  logic [N-1:0] q_p0;
  logic [1:0]   sel_p0;

  logic         vld_p0;
  logic         any_req;
  logic         load;
  logic         take;
  logic [1:0]   grant;
  logic [3:0]   ack_c;

  // First requester at or after p, wrapping mod 4; scanning downward lets
  // the lowest offset overwrite the others.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] mux4(input logic [1:0]   s,
                                        input logic [N-1:0] a,
                                        input logic [N-1:0] b,
                                        input logic [N-1:0] c,
                                        input logic [N-1:0] d);
    logic [N-1:0] w;
    case (s)
      2'd0:    w = a;
      2'd1:    w = b;
      2'd2:    w = c;
      default: w = d;
    endcase
    return w;
  endfunction

  assign vld_p0  = (state_p0 == FULL);
  assign any_req = |bus.req;
  assign load    = !vld_p0 || bus.q_ready;
  assign grant   = rr_pick(bus.req, ptr_p0);
  // Reset gates the capture so no ack can escape while rst_n is low.
  assign take    = load && any_req && rst_n;

  always_comb begin
    ack_c = 4'b0000;
    if (take) ack_c[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state_p0;
    ptr_nxt   = ptr_p0;
    case (state_p0)
      EMPTY: begin
        if (any_req) state_nxt = FULL;
      end
      FULL: begin
        if (bus.q_ready && !any_req) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (take) ptr_nxt = grant + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= EMPTY;
      ptr_p0   <= 2'd0;
    end else begin
      state_p0 <= state_nxt;
      ptr_p0   <= ptr_nxt;
    end
  end

  // Stage p0: captured word and its source code; held when nothing is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0   <= '0;
      sel_p0 <= 2'd0;
    end else if (take) begin
      q_p0   <= mux4(grant, bus.X1, bus.X2, bus.X3, bus.X4);
      sel_p0 <= grant;
    end
  end

  assign bus.ack     = ack_c;
  assign bus.select  = sel_p0;
  assign bus.q       = q_p0;
  assign bus.q_valid = vld_p0;

endmodule

// File: tb/tb_rr_sel4_arb.sv
// Directed bench for rr_sel4_arb: stimulus pushes the expected word/select
// at each grant, a negedge monitor pops and compares every accepted output.
module tb_rr_sel4_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [63:0] xv [4];

  rr_sel4_if #(.N(64)) bus ();

  rr_sel4_arb #(.N(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.X1 = xv[0];
  assign bus.X2 = xv[1];
  assign bus.X3 = xv[2];
  assign bus.X4 = xv[3];

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Source g should be acked now; its current word will appear on q next cycle.
  task automatic expect_grant(input int g, input string name);
    exp_t e;
    chk(name, 64'(bus.ack), 64'(1) << g);
    e.d = xv[g];
    e.s = 2'(g);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got q=%0h select=%0d expected no word", bus.q, bus.select);
      end else begin
        e = exp_q.pop_front();
        chk("mon_q", bus.q, e.d);
        chk("mon_select", 64'(bus.select), 64'(e.s));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    xv[0] = 64'h1111_1111_0000_0001;
    xv[1] = 64'h2222_2222_0000_0002;
    xv[2] = 64'h3333_3333_0000_0003;
    xv[3] = 64'h4444_4444_0000_0004;
    bus.req     = 4'b0000;
    bus.q_ready = 1'b1;
    #1;
    rst_n   = 1'b0;
    bus.req = 4'b1111;

    // Reset held with everyone requesting
    repeat (3) @(negedge clk);
    chk("rst_q_valid", 64'(bus.q_valid), 64'd0);
    chk("rst_q",       bus.q,            64'd0);
    chk("rst_select",  64'(bus.select),  64'd0);
    chk("rst_ack",     64'(bus.ack),     64'd0);

    // Release: first grant X1, then full rotation for 8 words
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      expect_grant(k % 4, "rr_ack");
    end
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("idle_ack",     64'(bus.ack),     64'd0);
    chk("last_q_valid", 64'(bus.q_valid), 64'd1);
    @(negedge clk);
    chk("drain_empty",  64'(bus.q_valid), 64'd0);

    // Single source X3 pulsed one cycle
    @(posedge clk); #1;
    xv[2]   = 64'hDEAD_BEEF_0000_0003;
    bus.req = 4'b0100;
    @(negedge clk);
    expect_grant(2, "single_ack");
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("single_q_valid", 64'(bus.q_valid), 64'd1);
    chk("single_select",  64'(bus.select),  64'd2);
    @(negedge clk);
    chk("single_empty",   64'(bus.q_valid), 64'd0);

    // ptr sits at 3: req 0011 wraps to X1, then X2
    @(posedge clk); #1;
    xv[1]   = 64'h2;
    bus.req = 4'b0011;
    @(negedge clk);
    expect_grant(0, "wrap_ack");
    @(negedge clk);
    expect_grant(1, "skip_ack");

    // Backpressure holding the X2 word
    @(posedge clk); #1;
    bus.q_ready = 1'b0;
    bus.req     = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ack",     64'(bus.ack),     64'd0);
      chk("bp_q",       bus.q,            64'h2);
      chk("bp_select",  64'(bus.select),  64'd1);
      chk("bp_q_valid", 64'(bus.q_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    expect_grant(2, "bp_resume_ack");
    @(negedge clk);
    expect_grant(3, "x4_ack");

    // Mid-operation asynchronous reset while holding the X4 word
    @(posedge clk); #1;
    bus.q_ready = 1'b0;
    bus.req     = 4'b0000;
    chk("full_select", 64'(bus.select), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_q_valid", 64'(bus.q_valid), 64'd0);
    chk("midrst_q",       bus.q,            64'd0);
    chk("midrst_select",  64'(bus.select),  64'd0);
    exp_q.delete();
    bus.req     = 4'b1000;
    bus.q_ready = 1'b1;
    #1;
    chk("midrst_ack", 64'(bus.ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_grant(3, "post_rst_ack");
    @(posedge clk); #1;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("post_rst_select", 64'(bus.select), 64'd3);
    @(negedge clk);
    chk("final_empty", 64'(bus.q_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
